// File: rtl/receiver_4phase_pkg.sv
// Shared constants for the 4-phase receiver: default data width and the 2-bit state encoding.
package receiver_4phase_pkg;

  localparam int unsigned DEF_DATA_MSB = 7;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACKED = 2'b01;

  // The holding buffer can take a new word when empty or when drained on the same edge.
  function automatic logic buf_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/receiver_4phase_dff.sv
// Single-bit D flop with asynchronous active-high reset; building block of the req synchronizer.
module dff (
  output logic q,
  input  logic d,
  input  logic clk,
  input  logic reset
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/receiver_4phase.sv
// Receive side of a 4-phase push synchronizer: syncs req, captures the data bus, drives ack,
// and hands words to the local consumer through a one-entry valid/ready buffer.
module receiver_4phase
  import receiver_4phase_pkg::*;
#(
  parameter int unsigned DATA_MSB    = DEF_DATA_MSB,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [DATA_MSB:0] input_rx,
  output logic              ack,
  output logic [DATA_MSB:0] output_rx,
  output logic              valid,
  input  logic              ready,
  output logic              got
);

  logic [SYNC_STAGES:0] sync_chain;
  logic                 req_s;

  logic [1:0]           state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 valid_q, valid_d;
  logic                 got_q, got_d;
  logic [DATA_MSB:0]    data_q, data_d;
  logic                 capture;

  assign sync_chain[0] = req;

  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    dff u_dff (
      .q     (sync_chain[i+1]),
      .d     (sync_chain[i]),
      .clk   (clk),
      .reset (reset)
    );
  end

  // Only the fully synchronized request drives any logic.
  assign req_s = sync_chain[SYNC_STAGES];

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        if (req_s && buf_free(valid_q, ready)) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_ACKED;
        end
      end
      ST_ACKED: begin
        ack_d = 1'b1;
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    got_d   = capture;
    data_d  = capture ? input_rx : data_q;
    valid_d = valid_q;
    if (capture) begin
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      got_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      got_q   <= got_d;
      data_q  <= data_d;
    end
  end

  assign ack       = ack_q;
  assign valid     = valid_q;
  assign got       = got_q;
  assign output_rx = data_q;

endmodule

// File: tb/tb_receiver_4phase.sv
// Bench for receiver_4phase: directed handshake scenarios plus a randomized foreign-domain
// transmitter, all checked every cycle against a transaction-level model of the receiver.
`timescale 1ns/100ps
module tb_receiver_4phase;

  localparam int SYNC = 2;
  localparam int NWORDS = 200;

  logic       clk = 1'b0;
  logic       tclk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [7:0] input_rx = 8'h00;
  logic       ack;
  logic [7:0] output_rx;
  logic       valid;
  logic       ready = 1'b0;
  logic       got;

  int n_cmp = 0;
  int n_bad = 0;

  receiver_4phase #(
    .DATA_MSB    (7),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .input_rx  (input_rx),
    .ack       (ack),
    .output_rx (output_rx),
    .valid     (valid),
    .ready     (ready),
    .got       (got)
  );

  always #5 clk = ~clk;
  // Transmitter clock: 27 ns period, edges on fractional times so they never meet a clk edge.
  initial begin
    #1.3;
    forever #13.5 tclk = ~tclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: req is seen SYNC edges late, ack acts as the handshake phase.
  logic       m_ack = 1'b0, m_valid = 1'b0, m_got = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         req_seen[$];
  bit         sb_on = 1'b0;
  int         sb_got = 0;
  logic [7:0] exp_q[$];

  initial begin : compare
    logic s_req, s_rdy, s_rst, req_s, cap;
    logic [7:0] s_din, w;
    forever begin
      @(posedge clk);
      s_req = req; s_rdy = ready; s_rst = reset; s_din = input_rx;
      if (s_rst) begin
        req_seen.delete();
        m_ack = 1'b0; m_valid = 1'b0; m_got = 1'b0; m_data = 8'h00;
      end else begin
        req_s = (req_seen.size() >= SYNC) ? req_seen[req_seen.size() - SYNC] : 1'b0;
        req_seen.push_back(s_req);
        if (req_seen.size() > SYNC) void'(req_seen.pop_front());
        cap = !m_ack && req_s && (!m_valid || s_rdy);
        m_got = cap;
        if (cap) begin
          m_ack = 1'b1; m_valid = 1'b1; m_data = s_din;
        end else begin
          if (m_valid && s_rdy) m_valid = 1'b0;
          if (m_ack && !req_s) m_ack = 1'b0;
        end
      end
      @(negedge clk);
      chk("ack", ack, m_ack);
      chk("valid", valid, m_valid);
      chk("got", got, m_got);
      chk("output_rx", output_rx, m_data);
      if (sb_on && got === 1'b1) begin
        sb_got++;
        if (exp_q.size() == 0) begin
          chk("sb_extra_word", output_rx, 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          chk("sb_order", output_rx, w);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  bit tx_done = 1'b0;

  task automatic tx_run();
    int t;
    for (int k = 0; k < NWORDS; k++) begin
      @(posedge tclk);
      input_rx = 8'($urandom);
      exp_q.push_back(input_rx);
      req = 1'b1;
      t = 0;
      while (ack !== 1'b1 && t < 400) begin
        @(posedge tclk);
        t++;
      end
      if (t >= 400) begin
        chk("tx_ack_rise_timeout", t, 0);
        break;
      end
      @(posedge tclk);
      req = 1'b0;
      t = 0;
      while (ack !== 1'b0 && t < 400) begin
        @(posedge tclk);
        t++;
      end
      if (t >= 400) begin
        chk("tx_ack_fall_timeout", t, 0);
        break;
      end
    end
    tx_done = 1'b1;
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // 1. reset
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_ack", ack, 0);
    chk("rst_valid", valid, 0);
    chk("rst_got", got, 0);
    chk("rst_out", output_rx, 0);

    // 2. single word, ready high
    input_rx = 8'hA5; req = 1'b1; ready = 1'b1;
    cyc(2);
    chk("t2_ack_early", ack, 0);
    cyc(1);
    chk("t2_ack", ack, 1);
    chk("t2_got", got, 1);
    chk("t2_out", output_rx, 8'hA5);
    chk("t2_valid", valid, 1);
    req = 1'b0;
    cyc(2);
    chk("t2_ack_hold", ack, 1);
    cyc(1);
    chk("t2_ack_fall", ack, 0);

    // 3. back-pressure
    ready = 1'b0;
    input_rx = 8'h11; req = 1'b1;
    cyc(3);
    chk("t3_ack11", ack, 1);
    req = 1'b0;
    cyc(3);
    input_rx = 8'h22; req = 1'b1;
    cyc(6);
    chk("t3_stall_ack", ack, 0);
    chk("t3_stall_out", output_rx, 8'h11);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("t3_ack22", ack, 1);
    chk("t3_out22", output_rx, 8'h22);
    chk("t3_valid", valid, 1);
    req = 1'b0;
    cyc(3);

    // 4. capture and drain on the same edge
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    input_rx = 8'h44; req = 1'b1;
    cyc(3);
    req = 1'b0;
    cyc(3);
    input_rx = 8'h33; req = 1'b1;
    cyc(2);
    chk("t4_pending", output_rx, 8'h44);
    ready = 1'b1;
    cyc(1);
    chk("t4_valid", valid, 1);
    chk("t4_out", output_rx, 8'h33);
    chk("t4_got", got, 1);
    req = 1'b0;
    cyc(4);

    // sub-cycle req glitch never sampled: no capture
    req = 1'b1;
    #2;
    req = 1'b0;
    cyc(5);
    chk("glitch_ack", ack, 0);
    chk("glitch_valid", valid, 0);

    // 5. reset in ACKED
    input_rx = 8'h5A; req = 1'b1;
    cyc(4);
    chk("t5_acked", ack, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_valid", valid, 0);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    chk("t5_ack_early", ack, 0);
    cyc(1);
    chk("t5_reack", ack, 1);
    chk("t5_out", output_rx, 8'h5A);
    req = 1'b0;
    cyc(4);

    // 6. randomized foreign-domain transmitter
    sb_on = 1'b1;
    fork
      tx_run();
      begin
        while (!tx_done) begin
          @(negedge clk);
          #1;
          ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready = 1'b1;
    cyc(6);
    sb_on = 1'b0;
    chk("t6_words", sb_got, NWORDS);
    chk("t6_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
